// File: rtl/gps_ca_multi.sv
// Multi-channel GPS L1 C/A Gold-code generator: per-channel PRN taps, chip index,
// 1 ms epoch strobe, 20 ms counter and a code-phase slew (hold) handshake.
module gps_ca_multi #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SAT_WIDTH  = 6,
    parameter int unsigned SLEW_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic [NUM_CH*SAT_WIDTH-1:0]      sat,
    input  logic [NUM_CH-1:0]                prn_load,
    input  logic [NUM_CH-1:0]                slew_valid,
    input  logic [NUM_CH*SLEW_WIDTH-1:0]     slew_chips,
    output logic [NUM_CH-1:0]                slew_ready,
    output logic [NUM_CH-1:0]                code_out,
    output logic [NUM_CH*10-1:0]             chip_idx,
    output logic [NUM_CH-1:0]                epoch,
    output logic [NUM_CH*5-1:0]              ms_cnt
);

    localparam int unsigned IDX_W     = 10;
    localparam int unsigned MS_W      = 5;
    localparam int unsigned TAP_W     = 4;
    localparam logic [IDX_W-1:0] LAST_CHIP = IDX_W'(1022);
    localparam logic [MS_W-1:0]  LAST_MS   = MS_W'(19);

    // G2 tap pair (1-based stage numbers) for a PRN; invalid PRNs get a harmless pair
    function automatic logic [2*TAP_W-1:0] tap_pair(input logic [SAT_WIDTH-1:0] s);
        int unsigned si;
        logic [2*TAP_W-1:0] tp;
        si = 32'(s);
        case (si)
            1:  tp = {4'd2, 4'd6};
            2:  tp = {4'd3, 4'd7};
            3:  tp = {4'd4, 4'd8};
            4:  tp = {4'd5, 4'd9};
            5:  tp = {4'd1, 4'd9};
            6:  tp = {4'd2, 4'd10};
            7:  tp = {4'd1, 4'd8};
            8:  tp = {4'd2, 4'd9};
            9:  tp = {4'd3, 4'd10};
            10: tp = {4'd2, 4'd3};
            11: tp = {4'd3, 4'd4};
            12: tp = {4'd5, 4'd6};
            13: tp = {4'd6, 4'd7};
            14: tp = {4'd7, 4'd8};
            15: tp = {4'd8, 4'd9};
            16: tp = {4'd9, 4'd10};
            17: tp = {4'd1, 4'd4};
            18: tp = {4'd2, 4'd5};
            19: tp = {4'd3, 4'd6};
            20: tp = {4'd4, 4'd7};
            21: tp = {4'd5, 4'd8};
            22: tp = {4'd6, 4'd9};
            23: tp = {4'd1, 4'd3};
            24: tp = {4'd4, 4'd6};
            25: tp = {4'd5, 4'd7};
            26: tp = {4'd6, 4'd8};
            27: tp = {4'd7, 4'd9};
            28: tp = {4'd8, 4'd10};
            29: tp = {4'd1, 4'd6};
            30: tp = {4'd2, 4'd7};
            31: tp = {4'd3, 4'd8};
            32: tp = {4'd4, 4'd9};
            default: tp = {4'd1, 4'd1};
        endcase
        return tp;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SAT_WIDTH-1:0]  sat_c;
        logic [SLEW_WIDTH-1:0] slew_c;
        logic                  valid;
        logic                  ready;
        logic [TAP_W-1:0]      t1;
        logic [TAP_W-1:0]      t2;
        logic [IDX_W-1:0]      g1;
        logic [IDX_W-1:0]      g2;
        logic [IDX_W-1:0]      idx;
        logic [MS_W-1:0]       ms;
        logic [SLEW_WIDTH-1:0] hold;
        logic                  ep;

        assign sat_c    = sat[c*SAT_WIDTH +: SAT_WIDTH];
        assign slew_c   = slew_chips[c*SLEW_WIDTH +: SLEW_WIDTH];
        assign valid    = (sat_c != '0) && (32'(sat_c) <= 32'd32);
        assign ready    = (hold == '0) && valid;
        assign {t1, t2} = tap_pair(sat_c);

        // Stage n of each LFSR lives in bit n-1; invalid PRN pins the channel in its load state
        always_ff @(posedge clk) begin
            ep <= 1'b0;
            if (reset || prn_load[c] || !valid) begin
                g1   <= '1;
                g2   <= '1;
                idx  <= '0;
                ms   <= '0;
                hold <= '0;
            end else begin
                if (ch_en[c] && en) begin
                    if (hold != '0) begin
                        hold <= hold - SLEW_WIDTH'(1);
                    end else if (idx == LAST_CHIP) begin
                        idx <= '0;
                        g1  <= '1;
                        g2  <= '1;
                        ms  <= (ms == LAST_MS) ? '0 : ms + MS_W'(1);
                        ep  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        g1  <= {g1[8:0], g1[2] ^ g1[9]};
                        g2  <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
                    end
                end
                // Acceptance only happens with hold at zero, so it never races the decrement
                if (slew_valid[c] && ready) begin
                    hold <= slew_c;
                end
            end
        end

        assign code_out[c]               = valid & (g1[9] ^ g2[t1 - TAP_W'(1)] ^ g2[t2 - TAP_W'(1)]);
        assign slew_ready[c]             = ready;
        assign chip_idx[c*IDX_W +: IDX_W] = idx;
        assign ms_cnt[c*MS_W +: MS_W]     = ms;
        assign epoch[c]                  = ep;
    end

endmodule
